// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_arbiter
// Purpose  : Shares a dual-port data RAM (one read port, one write port)
//            between the CPU and two external requesters (monitor, DMA).
//            The CPU normally owns both ports. An external access is granted
//            at once on whichever port the CPU leaves free this cycle. If it
//            keeps conflicting for STARVE_MAX cycles, the CPU is stalled and
//            the external access then takes the port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cpu_re_i / cpu_radr_i      CPU read enable and read word address
//   cpu_we_i / cpu_wadr_i      CPU store byte enables and write word address
//   cpu_wdata_i                CPU store data (byte-aligned)
//   cpu_stall_req_o            registered pipeline stall request
//   mon_* / dma_*              external request/grant/read-return channels
//   ram_*                      RAM port drive (1-cycle read latency)
// ============================================================================
module data_ram_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_re_i,
  input  logic [11:0] cpu_radr_i,
  input  logic [3:0]  cpu_we_i,
  input  logic [11:0] cpu_wadr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_stall_req_o,
  input  logic        mon_req_i,
  input  logic        mon_we_i,
  input  logic [11:0] mon_adr_i,
  input  logic [31:0] mon_wdata_i,
  output logic        mon_gnt_o,
  output logic        mon_rvalid_o,
  output logic [31:0] mon_rdata_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [11:0] dma_adr_i,
  input  logic [15:0] dma_wdata_i,
  output logic        dma_gnt_o,
  output logic        dma_rvalid_o,
  output logic [15:0] dma_rdata_o,
  output logic [11:0] ram_radr_o,
  output logic [11:0] ram_wadr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_wen_o,
  input  logic [31:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESTALL = 2'd1,
    ST_FORCE    = 2'd2
  } state_e;

  localparam logic [2:0] C_STARVE_THR = 3'(STARVE_MAX - 1);
  localparam logic [2:0] C_WAIT_SAT   = 3'd7;

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic        rr_q, rr_d;          // 0: monitor wins a tie, 1: DMA wins
  logic        stall_q, stall_d;
  logic        mon_rvalid_q, mon_rvalid_d;
  logic        dma_rvalid_q, dma_rvalid_d;

  logic        mon_conf, dma_conf;
  logic        mon_cand, dma_cand;
  logic        mon_gnt, dma_gnt;
  logic        any_req, any_gnt;

  always_comb begin
    // A read needs the read port, a write needs the write port.
    mon_conf = mon_we_i ? (cpu_we_i != 4'b0000) : cpu_re_i;
    dma_conf = dma_we_i ? (cpu_we_i != 4'b0000) : cpu_re_i;

    mon_cand = 1'b0;
    dma_cand = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mon_cand = mon_req_i & ~mon_conf;
        dma_cand = dma_req_i & ~dma_conf;
      end
      ST_FORCE: begin
        // CPU is stalled: the external winner overrides whatever it drives.
        mon_cand = mon_req_i;
        dma_cand = dma_req_i;
      end
      default: begin
        mon_cand = 1'b0;
        dma_cand = 1'b0;
      end
    endcase

    mon_gnt = ~rst & mon_cand & (~dma_cand | ~rr_q);
    dma_gnt = ~rst & dma_cand & (~mon_cand |  rr_q);
    any_gnt = mon_gnt | dma_gnt;
    any_req = mon_req_i | dma_req_i;

    rr_d = any_gnt ? ~rr_q : rr_q;

    // Starvation counter: consecutive pending-but-ungranted cycles.
    wait_d = wait_q;
    if (!any_req || any_gnt) begin
      wait_d = 3'd0;
    end else if (wait_q != C_WAIT_SAT) begin
      wait_d = wait_q + 3'd1;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Pending and ungranted in IDLE can only mean a port conflict.
        if (any_req && !any_gnt && (wait_q >= C_STARVE_THR)) begin
          state_d = ST_PRESTALL;
        end
      end
      ST_PRESTALL: state_d = ST_FORCE;
      ST_FORCE:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    stall_d      = (state_d != ST_IDLE);
    mon_rvalid_d = mon_gnt & ~mon_we_i;
    dma_rvalid_d = dma_gnt & ~dma_we_i;

    // RAM port muxing: external access replaces the CPU on its port only.
    ram_radr_o  = cpu_radr_i;
    ram_wadr_o  = cpu_wadr_i;
    ram_wdata_o = cpu_wdata_i;
    ram_wen_o   = rst ? 4'b0000 : cpu_we_i;
    if (mon_gnt) begin
      if (mon_we_i) begin
        ram_wadr_o  = mon_adr_i;
        ram_wdata_o = mon_wdata_i;
        ram_wen_o   = 4'b1111;
      end else begin
        ram_radr_o  = mon_adr_i;
      end
    end else if (dma_gnt) begin
      if (dma_we_i) begin
        ram_wadr_o  = dma_adr_i;
        ram_wdata_o = {16'h0000, dma_wdata_i};
        ram_wen_o   = 4'b1111;
      end else begin
        ram_radr_o  = dma_adr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_q       <= 3'd0;
      rr_q         <= 1'b0;
      stall_q      <= 1'b0;
      mon_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      rr_q         <= rr_d;
      stall_q      <= stall_d;
      mon_rvalid_q <= mon_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign cpu_stall_req_o = stall_q;
  assign mon_gnt_o       = mon_gnt;
  assign dma_gnt_o       = dma_gnt;
  assign mon_rvalid_o    = mon_rvalid_q;
  assign dma_rvalid_o    = dma_rvalid_q;
  assign mon_rdata_o     = ram_rdata_i;
  assign dma_rdata_o     = ram_rdata_i[15:0];

endmodule
`default_nettype wire

// File: doc/data_ram_arbiter.md
DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: cycles a pending external request waits before the arbiter forces a CPU stall.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cpu_re  in  1  CPU load using RAM read port this cycle.
REQ-005 cpu_radr  in  12  CPU read word address [13:2].
REQ-006 cpu_we  in  4  CPU store byte enables.
REQ-007 cpu_wadr  in  12  CPU write word address.
REQ-008 cpu_wdata  in  32  CPU store data, already byte-aligned.
REQ-009 cpu_stall_req  out  1  registered pipeline stall request.
REQ-010 mon_req / dma_req  in  1  monitor / DMA request, held until granted.
REQ-011 mon_we / dma_we  in  1  1 = write, 0 = read.
REQ-012 mon_adr / dma_adr  in  12  word address.
REQ-013 mon_wdata  in  32;  dma_wdata  in  16  write data (DMA zero-extended to 32).
REQ-014 mon_gnt / dma_gnt  out  1  one-cycle grant, combinational, same cycle the access drives the RAM.
REQ-015 mon_rvalid / dma_rvalid  out  1  registered, read data valid.
REQ-016 mon_rdata  out  32;  dma_rdata  out  16  equal to ram_rdata / ram_rdata[15:0].
REQ-017 ram_radr, ram_wadr  out  12;  ram_wdata  out  32;  ram_wen  out  4;  ram_rdata  in  32 (1-cycle read latency).

Function
REQ-018 At most one external grant per cycle; mon_gnt and dma_gnt never both high.
REQ-019 Port conflict: an external read conflicts when cpu_re=1; an external write conflicts when cpu_we!=0.
REQ-020 States: IDLE, PRESTALL, FORCE.
REQ-021 IDLE: a pending external request without conflict is granted immediately; the CPU access proceeds on the other port untouched.
REQ-022 Both external requests pending: round-robin; pointer toggles after each grant; reset pointer favours mon.
REQ-023 wait_cnt (3-bit, saturating) counts consecutive cycles in which any external request is pending and ungranted; it clears on any grant.
REQ-024 IDLE -> PRESTALL when wait_cnt reaches STARVE_MAX-1 in a conflicting cycle; cpu_stall_req rises at the next edge.
REQ-025 PRESTALL: cpu_stall_req=1; CPU access still drives the RAM; no external grant; next state FORCE.
REQ-026 FORCE: cpu_stall_req=1; round-robin winner granted regardless of conflict; the conflicting CPU port output is suppressed (ram_wen=0 or ram_radr from external); next state IDLE, cpu_stall_req falls at the next edge.
REQ-027 The stalled CPU repeats its access after release; the arbiter holds no CPU state.
REQ-028 Port muxing: granted external write drives ram_wadr/ram_wdata with ram_wen=4'b1111, otherwise CPU signals; granted external read drives ram_radr, otherwise cpu_radr.
REQ-029 rvalid asserts exactly one cycle after a read grant, for one cycle, to the granted requester only.
REQ-030 A request dropped before grant is ignored; wait_cnt clears when no request is pending.
REQ-031 Read and write grants to the same address in one cycle: write proceeds, read returns old data (RAM behaviour, not arbitrated).

Reset
REQ-032 While rst=1: state IDLE, wait_cnt=0, pointer=mon, all gnt/rvalid/cpu_stall_req=0, ram_wen=0.
REQ-033 rst asserted in PRESTALL or FORCE: cpu_stall_req=0 and the pending grant is cancelled the next cycle; no stray rvalid.

Verification
REQ-034 cpu_re=0, mon_req=1 read adr 0x010 -> mon_gnt same cycle, mon_rvalid next cycle, mon_rdata = RAM[0x010].
REQ-035 cpu_we=4'hF held, dma_req write, STARVE_MAX=4 -> cpu_stall_req high from cycle 4; dma_gnt in cycle 5 with ram_wen=4'hF, dma data on ram_wdata; stall low in cycle 6.
REQ-036 mon and dma reads pending, no conflict -> grants alternate mon, dma, mon; each rvalid one cycle after its grant.
REQ-037 cpu_re=1, dma write, cpu_we=0 -> dma_gnt immediately, CPU read unaffected, cpu_stall_req never asserted.
REQ-038 rst pulse in FORCE -> next cycle all gnt, rvalid, cpu_stall_req = 0, state IDLE.
